// File: rtl/mem_wait_unit.sv
// Unified instruction/data memory front-end: selects PC or ALU address, inserts
// LATENCY wait states, and reports completion with ready/err plus a busy hold.
module mem_wait_unit #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              i_or_d,
    input  logic [DATA_W-1:0] pc_addr,
    input  logic [DATA_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ready,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic [AW-1:0]     idx_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              write_reg, mis_reg, oor_reg, flag_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              ready_reg, err_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] req_addr;
    logic              req, req_mis, req_oor, access;

    assign req      = mem_read | mem_write;
    assign req_addr = i_or_d ? alu_addr : pc_addr;
    assign req_mis  = |req_addr[1:0];
    assign req_oor  = |req_addr[DATA_W-1:AW+2];
    // The single access edge: last wait state of the current request.
    assign access   = (state_reg == WAIT) && (cnt_reg == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = WAIT;
            WAIT:    if (cnt_reg == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
            mis_reg   <= 1'b0;
            oor_reg   <= 1'b0;
            flag_reg  <= 1'b0;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            ready_reg <= access;
            err_reg   <= access && flag_reg;
            if (state_reg == IDLE && req) begin
                cnt_reg   <= 4'(LATENCY);
                idx_reg   <= req_addr[AW+1:2];
                wdata_reg <= wdata;
                write_reg <= mem_write;
                mis_reg   <= req_mis;
                oor_reg   <= req_oor;
                flag_reg  <= req_mis | req_oor | (mem_read & mem_write);
            end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            // Out-of-range reads zero rdata; misaligned reads leave it alone.
            if (access && !write_reg) begin
                if (oor_reg)       rdata_reg <= '0;
                else if (!mis_reg) rdata_reg <= mem[idx_reg];
            end
        end
    end

    // Array has no reset; reset forces IDLE so an aborted access never writes.
    always_ff @(posedge clk) begin
        if (access && write_reg && !mis_reg && !oor_reg)
            mem[idx_reg] <= wdata_reg;
    end

    assign rdata = rdata_reg;
    assign ready = ready_reg;
    assign err   = err_reg;
endmodule
